// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply controller computing X^E mod M by driving
// one external Montgomery multiplier core, one multiplication in flight at a time.
module montgomery_exp #(
  parameter int N     = 1024,
  parameter int EXP_W = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [N-1:0]     in_x,
  input  logic [EXP_W-1:0] in_e,
  input  logic [N-1:0]     in_m,
  input  logic [N-1:0]     in_r,
  input  logic [N-1:0]     in_r2,
  output logic [N-1:0]     result,
  output logic             done,
  output logic             busy,
  output logic             mont_start,
  output logic [N-1:0]     mont_a,
  output logic [N-1:0]     mont_b,
  output logic [N-1:0]     mont_m,
  input  logic [N-1:0]     mont_result,
  input  logic             mont_done
);
  localparam int CNT_W = $clog2(EXP_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_SQ, S_MUL, S_NEXT, S_FROMMONT, S_WAIT, S_FIN
  } state_t;

  state_t           r_state, w_next_state, r_ret;
  logic [N-1:0]     r_xm, r_acc, r_result, r_mont_a, r_mont_b, r_mont_m;
  logic [N-1:0]     w_op_a, w_op_b;
  logic [EXP_W-1:0] r_e_sh;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_done, r_busy, r_mont_start;
  logic             w_issue, w_accept, w_core_done;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_core_done = (r_state == S_WAIT) && mont_done;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_op_a       = r_acc;
    w_op_b       = r_acc;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_TOMONT;
      S_TOMONT: begin
        // X and R^2 were parked on the operand registers when the run was accepted.
        w_issue      = 1'b1;
        w_op_a       = r_mont_a;
        w_op_b       = r_mont_b;
        w_next_state = S_WAIT;
      end
      S_SQ: begin
        w_issue      = 1'b1;
        w_next_state = S_WAIT;
      end
      S_MUL: begin
        w_issue      = 1'b1;
        w_op_b       = r_xm;
        w_next_state = S_WAIT;
      end
      S_FROMMONT: begin
        w_issue      = 1'b1;
        w_op_b       = {{(N-1){1'b0}}, 1'b1};
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (mont_done) begin
          case (r_ret)
            S_TOMONT: w_next_state = S_SQ;
            S_SQ:     w_next_state = r_e_sh[EXP_W-1] ? S_MUL : S_NEXT;
            S_MUL:    w_next_state = S_NEXT;
            default:  w_next_state = S_FIN;
          endcase
        end
      end
      S_NEXT:  w_next_state = (r_bit_cnt == CNT_W'(1)) ? S_FROMMONT : S_SQ;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_ret        <= S_IDLE;
      r_bit_cnt    <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_mont_start <= 1'b0;
      r_mont_a     <= '0;
      r_mont_b     <= '0;
      r_mont_m     <= '0;
    end else begin
      r_state      <= w_next_state;
      r_mont_start <= w_issue;
      r_done       <= w_core_done && (r_ret == S_FROMMONT);
      if (w_issue) begin
        r_ret    <= r_state;
        r_mont_a <= w_op_a;
        r_mont_b <= w_op_b;
      end
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_bit_cnt <= CNT_W'(EXP_W);
        r_mont_m  <= in_m;
        r_mont_a  <= in_x;
        r_mont_b  <= in_r2;
      end
      if (w_core_done && (r_ret == S_FROMMONT)) r_result <= mont_result;
      if (r_state == S_NEXT) r_bit_cnt <= r_bit_cnt - CNT_W'(1);
      // busy drops on the edge that ends the done cycle, so it covers the pulse.
      if (r_state == S_FIN) r_busy <= 1'b0;
    end
  end

  // NOTE: working registers carry no reset; each is loaded before it is read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc  <= in_r;
      r_e_sh <= in_e;
    end
    if (w_core_done && (r_ret == S_TOMONT)) r_xm <= mont_result;
    if (w_core_done && ((r_ret == S_SQ) || (r_ret == S_MUL))) r_acc <= mont_result;
    if (r_state == S_NEXT) r_e_sh <= r_e_sh << 1;
  end

  assign result     = r_result;
  assign done       = r_done;
  assign busy       = r_busy;
  assign mont_start = r_mont_start;
  assign mont_a     = r_mont_a;
  assign mont_b     = r_mont_b;
  assign mont_m     = r_mont_m;
endmodule

// File: tb/tb_montgomery_exp.sv
// Bench for montgomery_exp at reduced width, paired with a behavioural Montgomery
// core of random latency; results are compared against plain modular exponentiation.
module tb_montgomery_exp;
  localparam int N     = 16;
  localparam int EXP_W = 8;

  logic             clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [N-1:0]     in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [EXP_W-1:0] in_e = '0;
  logic [N-1:0]     result, mont_a, mont_b, mont_m;
  logic             done, busy, mont_start;
  logic [N-1:0]     mont_result = '0;
  logic             mont_done = 1'b0;

  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  montgomery_exp #(.N(N), .EXP_W(EXP_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done)
  );

  // a*b*2^-N mod m: halve modulo the odd m, N times.
  function automatic logic [N-1:0] mont_mul(input longint unsigned a, b, m);
    longint unsigned t = a * b;
    for (int i = 0; i < N; i++) begin
      if (t[0]) t = t + m;
      t = t >> 1;
    end
    return N'(t % m);
  endfunction

  function automatic longint unsigned ref_pow(input longint unsigned x, e, m);
    longint unsigned r = 1 % m, b = x % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // Core model with protocol monitor.
  logic [N-1:0] c_a = '0, c_b = '0;
  int           c_cnt = 0, starts_seen = 0, proto_err = 0;
  bit           c_busy = 1'b0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_busy    <= 1'b0;
      c_cnt     <= 0;
      mont_done <= 1'b0;
    end else begin
      mont_done <= 1'b0;
      if (mont_start) starts_seen <= starts_seen + 1;
      if (c_busy && (mont_start || mont_a !== c_a || mont_b !== c_b)) proto_err <= proto_err + 1;
      if (mont_start && !c_busy) begin
        c_busy <= 1'b1;
        c_a    <= mont_a;
        c_b    <= mont_b;
        c_cnt  <= int'($urandom_range(3, 0));
      end else if (c_busy) begin
        if (c_cnt == 0) begin
          mont_done   <= 1'b1;
          mont_result <= mont_mul(c_a, c_b, mont_m);
          c_busy      <= 1'b0;
        end else c_cnt <= c_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [N-1:0] x, input logic [EXP_W-1:0] e, input logic [N-1:0] m);
    longint unsigned one = 1, r;
    r     = (one << N) % longint'(m);
    in_x  = x;
    in_e  = e;
    in_m  = m;
    in_r  = N'(r);
    in_r2 = N'((r * r) % longint'(m));
    start = 1'b1;
  endtask

  task automatic garble();
    in_x  = N'($urandom);
    in_e  = EXP_W'($urandom);
    in_m  = N'($urandom);
    in_r  = N'($urandom);
    in_r2 = N'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  function automatic int exp_ops(input logic [EXP_W-1:0] e);
    return 2 + EXP_W + $countones(e);
  endfunction

  task automatic run_op(input string tag, input logic [N-1:0] x, input logic [EXP_W-1:0] e,
                        input logic [N-1:0] m, input logic [N-1:0] exp_res);
    int s0;
    bit ok;
    @(negedge clk);
    s0 = starts_seen;
    start_op(x, e, m);
    @(negedge clk);
    start = 1'b0;
    garble();
    wait_done(ok);
    check({tag, " done seen"}, 64'(ok), 64'd1);
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " busy at done"}, 64'(busy), 64'd1);
    check({tag, " op count"}, 64'(starts_seen - s0), 64'(exp_ops(e)));
    @(negedge clk);
    check({tag, " done single pulse"}, 64'(done), 64'd0);
    check({tag, " busy after done"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [N-1:0]     x;
    logic [EXP_W-1:0] e;
    logic [N-1:0]     m;
    logic [N-1:0]     res;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [N-1:0]     x, m, x2, m2;
    logic [EXP_W-1:0] e, e2;
    int               s0, s1;
    bit               ok;

    tbl[0] = '{16'd3,     8'd5,   16'd1001,  16'd243};
    tbl[1] = '{16'd7,     8'd0,   16'd1001,  16'd1};
    tbl[2] = '{16'd77,    8'd1,   16'd1001,  16'd77};
    tbl[3] = '{16'd2,     8'd255, 16'd65535, 16'd32768};
    tbl[4] = '{16'd0,     8'd9,   16'd1,     16'd0};
    tbl[5] = '{16'd0,     8'd0,   16'd7,     16'd1};
    tbl[6] = '{16'd2,     8'd10,  16'd1023,  16'd1};
    tbl[7] = '{16'd65534, 8'd2,   16'd65535, 16'd1};

    repeat (3) @(negedge clk);
    check("reset result", 64'(result), 64'd0);
    check("reset done/busy/mont_start", 64'({done, busy, mont_start}), 64'd0);
    check("reset mont_a/b/m", 64'({mont_a, mont_b, mont_m}), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].x, tbl[i].e, tbl[i].m, tbl[i].res);

    for (int i = 0; i < 12; i++) begin
      m = N'($urandom_range(32767, 0) * 2 + 1);
      x = N'($urandom % 32'(m));
      e = EXP_W'($urandom);
      run_op($sformatf("rnd%0d", i), x, e, m, N'(ref_pow(x, e, m)));
    end

    // start held high: second run launches only after the done cycle.
    x = 16'd3;  e = 8'd13;  m = 16'd4097;
    x2 = 16'd1234; e2 = 8'd200; m2 = 16'd50001;
    @(negedge clk);
    s0 = starts_seen;
    start_op(x, e, m);
    wait_done(ok);
    check("hold done seen", 64'(ok), 64'd1);
    check("hold first result", 64'(result), 64'(N'(ref_pow(x, e, m))));
    check("hold first op count", 64'(starts_seen - s0), 64'(exp_ops(e)));
    s1 = starts_seen;
    start_op(x2, e2, m2);
    @(negedge clk);
    check("hold idle gap done", 64'(done), 64'd0);
    check("hold idle gap busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("hold retrigger busy", 64'(busy), 64'd1);
    start = 1'b0;
    garble();
    wait_done(ok);
    check("hold second done seen", 64'(ok), 64'd1);
    check("hold second result", 64'(result), 64'(N'(ref_pow(x2, e2, m2))));
    check("hold second op count", 64'(starts_seen - s1), 64'(exp_ops(e2)));
    @(negedge clk);

    // start pulsed mid-run is ignored.
    x = 16'd999; e = 8'd171; m = 16'd40003;
    @(negedge clk);
    s0 = starts_seen;
    start_op(x, e, m);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    start_op(16'd5, 8'd255, 16'd7);
    @(negedge clk);
    start = 1'b0;
    garble();
    wait_done(ok);
    check("midstart done seen", 64'(ok), 64'd1);
    check("midstart result", 64'(result), 64'(N'(ref_pow(x, e, m))));
    check("midstart op count", 64'(starts_seen - s0), 64'(exp_ops(e)));
    @(negedge clk);

    // Reset while a multiplication is outstanding.
    @(negedge clk);
    start_op(16'd321, 8'd77, 16'd60001);
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (c_busy) ok = 1'b1;
      else @(negedge clk);
    end
    check("abort reached wait", 64'(ok), 64'd1);
    resetn = 1'b0;
    #1;
    check("abort busy/done/mont_start", 64'({busy, done, mont_start}), 64'd0);
    check("abort result", 64'(result), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("post-abort", 16'd321, 8'd77, 16'd60001, N'(ref_pow(321, 77, 60001)));

    check("protocol violations", 64'(proto_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
